// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard controller.
package fwd_pkg;

  // Widest register specifier the slot history can hold; narrower REG_BITS
  // values are zero-extended into this field.
  localparam int unsigned RD_BITS_MAX = 8;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,  // register file (write-through)
    FWD_EXMEM = 2'd1,  // instruction one ahead
    FWD_MEMWB = 2'd2,  // instruction two ahead
    FWD_ZERO  = 2'd3   // constant zero for XZR reads
  } fwd_sel_e;

  typedef struct packed {
    logic [RD_BITS_MAX-1:0] rd;
    logic                   reg_write;
    logic                   mem_read;
  } pipe_slot_t;

  localparam pipe_slot_t BUBBLE_SLOT = '{rd: '0, reg_write: 1'b0, mem_read: 1'b0};

  // A slot can feed a source only if it writes that register and the
  // register is not XZR (writes to XZR are discarded).
  function automatic logic slot_feeds(input pipe_slot_t             slot,
                                      input logic [RD_BITS_MAX-1:0] src,
                                      input logic [RD_BITS_MAX-1:0] zero_reg);
    return slot.reg_write && (slot.rd == src) && (slot.rd != zero_reg);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and EX-stage forwarding response bundle.
interface fwd_hazard_unit_if
  import fwd_pkg::*;
#(
  parameter int unsigned REG_BITS = 5
);
  logic [REG_BITS-1:0] id_rn;
  logic [REG_BITS-1:0] id_rm;
  logic                id_rn_used;
  logic                id_rm_used;
  logic [REG_BITS-1:0] id_rd;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                flush;
  logic                stall;
  fwd_sel_e            fwd_a_sel;
  fwd_sel_e            fwd_b_sel;

  // Pipeline control side: presents the decoded instruction.
  modport master (
    output id_rn, id_rm, id_rn_used, id_rm_used, id_rd, id_reg_write,
           id_mem_read, flush,
    input  stall, fwd_a_sel, fwd_b_sel
  );

  // Hazard unit side.
  modport slave (
    input  id_rn, id_rm, id_rn_used, id_rm_used, id_rd, id_reg_write,
           id_mem_read, flush,
    output stall, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/fwd_src_sel.sv
// Per-operand forwarding select and load-use hazard detection.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic                used_i,
  input  logic [REG_BITS-1:0] src_i,
  input  pipe_slot_t          ex_slot_i,
  input  pipe_slot_t          mem_slot_i,
  output fwd_sel_e            sel_o,
  output logic                hazard_o
);

  logic [RD_BITS_MAX-1:0] src_w;
  logic [RD_BITS_MAX-1:0] zero_w;
  logic                   ex_hit;
  logic                   mem_hit;

  assign src_w  = RD_BITS_MAX'(src_i);
  assign zero_w = RD_BITS_MAX'(ZERO_REG);

  // Match each history slot against this operand's source register.
  always_comb begin
    ex_hit  = slot_feeds(ex_slot_i, src_w, zero_w);
    mem_hit = slot_feeds(mem_slot_i, src_w, zero_w);
  end

  // Priority: unused > XZR > youngest producer > older producer > regfile.
  always_comb begin
    // NOTE: every output gets a default before the if-chain; a path that
    // left one unassigned would infer a latch.
    sel_o    = FWD_REG;
    hazard_o = 1'b0;
    if (!used_i) begin
      sel_o = FWD_REG;
    end else if (src_w == zero_w) begin
      sel_o = FWD_ZERO;
    end else if (ex_hit) begin
      sel_o    = FWD_EXMEM;
      // A load one ahead has no result yet at EX, so decode must wait.
      hazard_o = ex_slot_i.mem_read;
    end else if (mem_hit) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller: tracks the destinations of the
// two instructions ahead of decode, stalls on load-use, and registers the
// EX-stage operand mux selects.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_BITS = 5,  // must not exceed RD_BITS_MAX
  parameter int unsigned ZERO_REG = 31
) (
  input logic               clk,
  input logic               reset,
  fwd_hazard_unit_if.slave  bus
);

  pipe_slot_t ex_slot_q,  ex_slot_d;
  pipe_slot_t mem_slot_q, mem_slot_d;
  fwd_sel_e   a_sel_q,    a_sel_d;
  fwd_sel_e   b_sel_q,    b_sel_d;
  fwd_sel_e   a_sel_c,    b_sel_c;
  logic       haz_a,      haz_b;
  logic       stall;

  fwd_src_sel #(.REG_BITS(REG_BITS), .ZERO_REG(ZERO_REG)) u_sel_a (
    .used_i     (bus.id_rn_used),
    .src_i      (bus.id_rn),
    .ex_slot_i  (ex_slot_q),
    .mem_slot_i (mem_slot_q),
    .sel_o      (a_sel_c),
    .hazard_o   (haz_a)
  );

  fwd_src_sel #(.REG_BITS(REG_BITS), .ZERO_REG(ZERO_REG)) u_sel_b (
    .used_i     (bus.id_rm_used),
    .src_i      (bus.id_rm),
    .ex_slot_i  (ex_slot_q),
    .mem_slot_i (mem_slot_q),
    .sel_o      (b_sel_c),
    .hazard_o   (haz_b)
  );

  // A taken branch kills the ID instruction, so its hazard is moot.
  always_comb begin
    stall = (haz_a | haz_b) & ~bus.flush;
  end

  // Next state: history shifts every cycle; a stall or flush injects a bubble.
  always_comb begin
    mem_slot_d = ex_slot_q;
    ex_slot_d  = BUBBLE_SLOT;
    a_sel_d    = FWD_REG;
    b_sel_d    = FWD_REG;
    if (!(stall || bus.flush)) begin
      ex_slot_d.rd        = RD_BITS_MAX'(bus.id_rd);
      ex_slot_d.reg_write = bus.id_reg_write;
      ex_slot_d.mem_read  = bus.id_mem_read;
      a_sel_d             = a_sel_c;
      b_sel_d             = b_sel_c;
    end
  end

  // Slot and select registers; reset empties history so nothing pre-reset
  // is ever forwarded.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      ex_slot_q  <= BUBBLE_SLOT;
      mem_slot_q <= BUBBLE_SLOT;
      a_sel_q    <= FWD_REG;
      b_sel_q    <= FWD_REG;
    end else begin
      ex_slot_q  <= ex_slot_d;
      mem_slot_q <= mem_slot_d;
      a_sel_q    <= a_sel_d;
      b_sel_q    <= b_sel_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.fwd_a_sel = a_sel_q;
  assign bus.fwd_b_sel = b_sel_q;

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard controller for the pipelined datapath. Tracks the destination registers of the two instructions ahead of decode in its own shift history, and stalls decode on a load-use hazard. Produces the registered 2-bit select for the two EX-stage operand `busMux4_1` instances: register file, EX/MEM result, MEM/WB result, or constant zero.

## Interface
- `REG_BITS`, default 5: register-specifier width.
- `ZERO_REG`, default 31: hard-wired zero register (XZR). Reads return 0; writes are never forwarded.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `id_rn`  in  REG_BITS: operand A source register of the instruction in ID.
- `id_rm`  in  REG_BITS: operand B source register of the instruction in ID.
- `id_rn_used`, `id_rm_used`  in  1 each: operand actually read by the ID instruction.
- `id_rd`  in  REG_BITS: destination register of the ID instruction.
- `id_reg_write`  in  1: ID instruction writes `id_rd`.
- `id_mem_read`  in  1: ID instruction is a load.
- `flush`  in  1: kill the ID instruction (taken branch).
- `stall`  out  1: hold PC and IF/ID; a bubble enters EX.
- `fwd_a_sel`  out  2: select for the operand-A mux, valid during EX.
- `fwd_b_sel`  out  2: select for the operand-B mux, valid during EX.

## Operation
- Select encoding:
  - 0 = register file
  - 1 = EX/MEM result (instruction one ahead)
  - 2 = MEM/WB result (instruction two ahead)
  - 3 = constant zero
- The register file is write-through. Instructions three or more ahead are never forwarded.
- History slots, each holding {rd, reg_write, mem_read}:
  - `ex_slot`: instruction now in EX.
  - `mem_slot`: instruction now in MEM.
- Per-operand selection, computed in the ID cycle, in priority order:
  - operand unused → 0
  - src == ZERO_REG → 3
  - ex_slot.reg_write and ex_slot.rd == src and ex_slot.rd != ZERO_REG → 1
  - mem_slot under the same condition → 2
  - otherwise → 0
- Hazard: a used operand, not ZERO_REG, matches ex_slot.rd while ex_slot.reg_write and ex_slot.mem_read are both set.
- `stall` = hazard & ~flush (combinational from the ID inputs and slot state).
- Clock edge, no reset:
  - `mem_slot` <= `ex_slot`.
  - If `stall` or `flush`: `ex_slot` <= bubble (all fields 0), and both selects <= 0.
  - Otherwise: `ex_slot` <= ID fields, and selects <= computed values.
- A stalled instruction is re-presented on the ID inputs next cycle. The load is then in `mem_slot`, so the recomputed select is 2 and `stall` drops. Load-use costs exactly one bubble.

## Timing
- Reset edge: both slots become bubbles, and `fwd_a_sel` = `fwd_b_sel` = 0. `stall` reads 0 from the following cycle (slots empty).
- A reset asserted mid-stall discards the pending hazard. No forwarding from pre-reset instructions.
- Select latency: computed in cycle N (ID), registered and presented in cycle N+1 (EX).
- Stall latency: `stall` is combinational in the same cycle as the hazarding ID instruction.
- Simultaneous `flush` and hazard: flush wins; `stall` = 0 and a bubble is inserted.
- Both operands matching different slots select independently. Both operands may select 1.
- An ID instruction whose `id_rd` equals its own source still forwards from the older slots only.

## Structure
- `fwd_pkg` contains:
  - enum `fwd_sel_e` {FWD_REG, FWD_EXMEM, FWD_MEMWB, FWD_ZERO} = 0..3
  - struct `pipe_slot_t` {rd, reg_write, mem_read}
  - constant `BUBBLE_SLOT`
- Sub-module `fwd_src_sel`: combinational per-operand priority select plus hazard bit. Instantiated twice, once for A and once for B.
- Top level contains the slot registers, select registers and stall/flush logic.

## Test plan
- Reset behaviour: assert `reset` two cycles with `id_rn`=3, `id_rn_used`=1 → selects = 0 and `stall` = 0 after the reset edge.
- EX/MEM forwarding: ADD X5 (rd=5, reg_write) followed by SUB with rn=5, rm=7 → in SUB's EX cycle `fwd_a_sel`=1, `fwd_b_sel`=0.
- MEM/WB forwarding and priority:
  - rd=5 writer, unrelated instruction, then reader rn=5 → `fwd_a_sel`=2.
  - Two consecutive writers of X5 → reader gets 1 (youngest wins).
- Zero register: writer rd=31, then reader rn=31, rm=31 → both selects = 3. No forwarding of the XZR write.
- Load-use hazard:
  - LDUR X9 then ADD rn=9 → `stall`=1 for exactly one cycle, and a bubble in EX gives selects 0.
  - The re-presented ADD then gets `fwd_a_sel`=2 in its EX cycle.
- Flush and reset interaction:
  - Hazard with `flush`=1 → `stall`=0, and the next EX selects = 0.
  - `reset` asserted during a load-use stall → `stall`=0 the cycle after, and the next reader rn=9 gets select 0.
